if_fetch: RTL and testbench

Instruction-fetch stage feeding the IF/ID pipeline register. It holds the program counter and looks up a small direct-mapped instruction cache. On a miss it requests the word from the memory controller and fills the line. It presents `if_pc`/`if_inst`/`if_valid` to IF/ID and honours the downstream stall and the branch/jump redirect from EX.

---
 rtl/if_fetch.sv | 134 +++++++++++++
 tb/tb_if_fetch.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line I-cache,
// miss handling against the memory controller, and registered IF/ID outputs.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IDX_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_stall,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        dbg_state_o
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [LINES-1:0] line_vld_q;
  logic [TAG_W-1:0] line_tag_q  [LINES];
  logic [31:0]      line_data_q [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill_en;
  logic             unused_jump_bits;

  assign idx      = pc_q[IDX_W+1:2];
  assign tag      = pc_q[31:IDX_W+2];
  assign fill_idx = mem_addr_q[IDX_W+1:2];
  assign fill_tag = mem_addr_q[31:IDX_W+2];
  assign hit      = line_vld_q[idx] && (line_tag_q[idx] == tag);

  // Memory handshake: mem_req rises with mem_addr and both stay stable until the
  // single-cycle mem_done pulse; the fill then lands even if a redirect arrived meanwhile.
  assign fill_en  = rdy && (state_q == S_MISS) && mem_done;

  assign unused_jump_bits = ^jump_addr[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (rdy) begin
      if ((state_q == S_MISS) && mem_done) begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
      if (jump_en) begin
        pc_d       = {jump_addr[31:2], 2'b00};
        if_valid_d = 1'b0;
      end else if ((state_q == S_IDLE) && !if_stall) begin
        if (hit) begin
          if_pc_d    = pc_q;
          if_inst_d  = line_data_q[idx];
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end else begin
          if_valid_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = S_MISS;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
      if_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      line_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if (fill_en) begin
        line_vld_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage need no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_tag_q[fill_idx]  <= fill_tag;
      line_data_q[fill_idx] <= mem_inst;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign if_valid    = if_valid_q;
  assign dbg_state_o = (state_q == S_MISS);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized run checked against a
// transaction-level model of the fetch stream and a direct-mapped cache.
module tb_if_fetch;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        if_stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_inst = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        dbg_state_o;

  int total = 0;
  int bad   = 0;

  // memory-controller model and per-edge observations
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  int          mem_lat  = 3;
  logic [31:0] mem_pend_addr = 32'h0;
  bit          spurious = 0;
  bit          s_pres, s_req, s_fill, s_held, s_moved;
  logic [31:0] s_fill_addr;
  int          edge_no = 0;

  if_fetch #(.RESET_PC(32'h0), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_stall(if_stall),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_inst(mem_inst),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  // One clock edge: apply inputs, let the memory model answer, observe after the edge.
  task automatic step(input bit r, input bit st, input bit je, input logic [31:0] ja);
    logic        prev_req;
    logic [31:0] prev_addr;
    rdy = r; if_stall = st; jump_en = je; jump_addr = ja;
    mem_done = 1'b0; s_fill = 0;
    if (spurious) begin
      mem_done = 1'b1; mem_inst = 32'hDEADBEEF; spurious = 0;
    end else if (r && mem_busy) begin
      if (mem_cnt <= 1) begin
        mem_done = 1'b1; mem_inst = mem_word(mem_pend_addr);
        mem_busy = 0; s_fill = 1; s_fill_addr = mem_pend_addr;
      end else begin
        mem_cnt--;
      end
    end
    prev_req = mem_req; prev_addr = mem_addr;
    @(posedge clk); #1;
    edge_no++;
    mem_done = 1'b0;
    s_pres  = r && !st && !je && (if_valid === 1'b1);
    s_req   = (mem_req === 1'b1) && (prev_req !== 1'b1);
    s_held  = (mem_req === 1'b1) && (prev_req === 1'b1);
    s_moved = s_held && (mem_addr !== prev_addr);
    if (s_req) begin
      mem_busy = 1; mem_cnt = mem_lat; mem_pend_addr = mem_addr;
    end
  endtask

  task automatic hold_reset();
    rdy = 0; if_stall = 0; jump_en = 0; jump_addr = 0; mem_done = 0;
    mem_busy = 0; spurious = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; edge_no = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1; #1;
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++; if (dbg_state_o !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", dbg_state_o); end
    hold_reset();
  endtask

  task automatic test_cold_fetch();
    int n = 0, nreq = 0, first_edge = -1, last_edge = -1;
    mem_lat = 3;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step(1, 0, 0, 32'h0);
      if (s_req) begin
        total++; if (mem_addr !== 32'(4 * nreq)) begin bad++; $display("FAIL cold_req%0d: got %h want %h", nreq, mem_addr, 32'(4 * nreq)); end
        total++; if (dbg_state_o !== 1'b1) begin bad++; $display("FAIL cold_state%0d: got %b want 1", nreq, dbg_state_o); end
        nreq++;
      end
      if (s_pres) begin
        total++; if (if_pc !== 32'(4 * n) || if_inst !== mem_word(32'(4 * n))) begin
          bad++; $display("FAIL cold_pres%0d: got (%h,%h) want (%h,%h)", n, if_pc, if_inst, 32'(4 * n), mem_word(32'(4 * n)));
        end
        if (n == 0) first_edge = edge_no;
        last_edge = edge_no;
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL cold_count: got %0d want 4", n); end
    total++; if (nreq != 4) begin bad++; $display("FAIL cold_reqs: got %0d want 4", nreq); end
    total++; if (first_edge != 5) begin bad++; $display("FAIL cold_latency: got edge %0d want 5", first_edge); end
    total++; if (last_edge != 20) begin bad++; $display("FAIL cold_last: got edge %0d want 20", last_edge); end
  endtask

  task automatic test_jump_hits();
    step(1, 0, 1, 32'h0);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL jh_bubble: got %b want 0", if_valid); end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 32'h0);
      total++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_inst !== mem_word(32'(4 * k)) || mem_req !== 1'b0) begin
        bad++; $display("FAIL jh_hit%0d: got v=%b pc=%h inst=%h req=%b want v=1 pc=%h inst=%h req=0",
                        k, if_valid, if_pc, if_inst, mem_req, 32'(4 * k), mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_stall();
    step(1, 1, 1, 32'h0);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL st_jump: got %b want 0", if_valid); end
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    total++; if (if_pc !== 32'h4 || if_valid !== 1'b1) begin bad++; $display("FAIL st_pre: got pc=%h v=%b want 4,1", if_pc, if_valid); end
    for (int k = 0; k < 3; k++) begin
      if (k == 1) spurious = 1;
      step(1, 1, 0, 32'h0);
      total++; if (if_pc !== 32'h4 || if_inst !== mem_word(32'h4) || if_valid !== 1'b1 || mem_req !== 1'b0) begin
        bad++; $display("FAIL st_hold%0d: got (%h,%h,%b,req=%b) want (4,%h,1,req=0)", k, if_pc, if_inst, if_valid, mem_req, mem_word(32'h4));
      end
    end
    step(0, 0, 0, 32'h0);
    total++; if (if_pc !== 32'h4 || if_valid !== 1'b1) begin bad++; $display("FAIL st_rdy0: got pc=%h v=%b want 4,1", if_pc, if_valid); end
    step(1, 0, 0, 32'h0);
    total++; if (if_pc !== 32'h8 || if_inst !== mem_word(32'h8) || if_valid !== 1'b1) begin
      bad++; $display("FAIL st_release: got (%h,%h,%b) want (8,%h,1)", if_pc, if_inst, if_valid, mem_word(32'h8));
    end
    step(1, 0, 0, 32'h0);
    total++; if (if_pc !== 32'hC || if_inst !== mem_word(32'hC) || mem_req !== 1'b0) begin
      bad++; $display("FAIL st_after_spur: got (%h,%h,req=%b) want (c,%h,req=0)", if_pc, if_inst, mem_req, mem_word(32'hC));
    end
  endtask

  task automatic test_jump_during_miss_and_alias();
    int nreq = 0; bit got = 0;
    mem_lat = 4;
    step(1, 0, 1, 32'h20);
    step(1, 0, 0, 32'h0);
    total++; if (!s_req || mem_addr !== 32'h20) begin bad++; $display("FAIL jm_req: got req=%b addr=%h want 1,20", s_req, mem_addr); end
    step(1, 0, 1, 32'h103);
    total++; if (if_valid !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL jm_inflight: got v=%b req=%b want 0,1", if_valid, mem_req); end
    for (int c = 0; c < 40 && !got; c++) begin
      step(1, 0, 0, 32'h0);
      if (s_req) begin
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL jm_next_req: got %h want 100", mem_addr); end
        nreq++;
      end
      if (s_pres) begin
        got = 1;
        total++; if (if_pc !== 32'h100 || if_inst !== mem_word(32'h100)) begin
          bad++; $display("FAIL jm_target: got (%h,%h) want (100,%h)", if_pc, if_inst, mem_word(32'h100));
        end
      end
    end
    total++; if (!got || nreq != 1) begin bad++; $display("FAIL jm_flow: got pres=%b reqs=%0d want 1,1", got, nreq); end
    step(1, 0, 1, 32'h20);
    step(1, 0, 0, 32'h0);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_inst !== mem_word(32'h20) || mem_req !== 1'b0) begin
      bad++; $display("FAIL jm_fill_kept: got v=%b pc=%h inst=%h req=%b want 1,20,%h,0", if_valid, if_pc, if_inst, mem_req, mem_word(32'h20));
    end
    step(1, 0, 1, 32'h0);
    step(1, 0, 0, 32'h0);
    total++; if (!s_req || mem_addr !== 32'h0) begin bad++; $display("FAIL alias_miss: got req=%b addr=%h want 1,0", s_req, mem_addr); end
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step(1, 0, 0, 32'h0);
      if (s_pres) got = 1;
    end
    total++; if (!got || if_pc !== 32'h0 || if_inst !== mem_word(32'h0)) begin
      bad++; $display("FAIL alias_refill: got pres=%b (%h,%h) want 1 (0,%h)", got, if_pc, if_inst, mem_word(32'h0));
    end
  endtask

  task automatic test_async_reset_mid_miss();
    bit got = 0;
    mem_lat = 5;
    step(1, 0, 1, 32'h40);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL ar_setup: got req=%b addr=%h want 1,40", mem_req, mem_addr); end
    #3 rst = 1'b1; #1;
    total++; if (if_pc !== 0 || if_inst !== 0 || if_valid !== 0 || mem_req !== 0 || mem_addr !== 0 || dbg_state_o !== 0) begin
      bad++; $display("FAIL ar_zero: got pc=%h inst=%h v=%b req=%b addr=%h st=%b want all 0", if_pc, if_inst, if_valid, mem_req, mem_addr, dbg_state_o);
    end
    hold_reset();
    mem_lat = 2;
    step(1, 0, 0, 32'h0);
    total++; if (!s_req || mem_addr !== 32'h0) begin bad++; $display("FAIL ar_restart: got req=%b addr=%h want 1,0", s_req, mem_addr); end
    for (int c = 0; c < 20 && !got; c++) begin
      step(1, 0, 0, 32'h0);
      if (s_pres) got = 1;
    end
    total++; if (!got || if_pc !== 32'h0 || if_inst !== mem_word(32'h0)) begin
      bad++; $display("FAIL ar_first: got pres=%b (%h,%h) want 1 (0,%h)", got, if_pc, if_inst, mem_word(32'h0));
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [31:0] exp_q[$];
    exp_q = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0};
    mem_lat = 1;
    step(1, 0, 1, 32'hFFFFFFFB);
    for (int c = 0; c < 60 && n < 3; c++) begin
      step(1, 0, 0, 32'h0);
      if (s_pres) begin
        total++; if (if_pc !== exp_q[n] || if_inst !== mem_word(exp_q[n])) begin
          bad++; $display("FAIL wrap%0d: got (%h,%h) want (%h,%h)", n, if_pc, if_inst, exp_q[n], mem_word(exp_q[n]));
        end
        n++;
      end
    end
    total++; if (n != 3) begin bad++; $display("FAIL wrap_count: got %0d want 3", n); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] m_line [int];
    bit r, st, je, hit_m;
    logic [31:0] ja;
    int npres = 0;
    rst = 1'b1;
    hold_reset();
    exp_pc = 32'h0;
    for (int c = 0; c < 2500; c++) begin
      r  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 9) < 3);
      je = ($urandom_range(0, 19) == 0);
      ja = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) ja = ja | 32'h1000;
      mem_lat = $urandom_range(1, 5);
      step(r, st, je, ja);
      if (s_fill) m_line[line_of(s_fill_addr)] = s_fill_addr;
      hit_m = m_line.exists(line_of(exp_pc)) && (m_line[line_of(exp_pc)] == exp_pc);
      if (r && je) begin
        exp_pc = {ja[31:2], 2'b00};
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rnd_jump_bubble@%0d: got %b want 0", c, if_valid); end
      end else if (s_pres) begin
        total++; if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc) || !hit_m) begin
          bad++; $display("FAIL rnd_pres@%0d: got (%h,%h) want (%h,%h) model_hit=%b", c, if_pc, if_inst, exp_pc, mem_word(exp_pc), hit_m);
        end
        exp_pc = exp_pc + 32'd4;
        npres++;
      end
      if (s_req) begin
        total++; if (mem_addr !== exp_pc || hit_m) begin
          bad++; $display("FAIL rnd_req@%0d: got addr=%h want %h model_hit=%b", c, mem_addr, exp_pc, hit_m);
        end
      end
      if (s_held) begin
        total++; if (s_moved) begin bad++; $display("FAIL rnd_addr_stable@%0d: got %h want %h", c, mem_addr, mem_pend_addr); end
      end
    end
    total++; if (npres < 100) begin bad++; $display("FAIL rnd_progress: got %0d presentations want >=100", npres); end
  endtask

  initial begin
    test_reset();
    test_cold_fetch();
    test_jump_hits();
    test_stall();
    test_jump_during_miss_and_alias();
    test_async_reset_mid_miss();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
